cpu_bus_ctrl: RTL and testbench

CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

---
 rtl/cpu_bus_ctrl.sv | 78 +++++++
 tb/tb_cpu_bus_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: single-outstanding core-to-memory bus sequencer (IDLE/BUSY/DONE).
// Optional bus timeout when CPU_BUS_TIMEOUT_EN is defined.
module cpu_bus_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  rdata,
    output logic        done,
    output logic        stall,
    output logic        err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic       accept;
    logic       timeout;

    assign accept  = (state == IDLE) && req;
    assign mem_req = (state == BUSY);
    assign done    = (state == DONE);
    assign stall   = (state == BUSY) || accept;

`ifdef CPU_BUS_TIMEOUT_EN
    logic [3:0] cnt;
    // ack in the same cycle as the last count wins over the timeout
    assign timeout = (state == BUSY) && !mem_ack && (cnt == 4'hF);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'h0;
            err <= 1'b0;
        end else begin
            cnt <= accept ? 4'h0 : (state == BUSY && !mem_ack) ? cnt + 4'h1 : cnt;
            err <= accept ? 1'b0 : timeout ? 1'b1 : err;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            rdata     <= 8'h00;
        end else begin
            case (state)
                IDLE: if (req) begin
                    mem_addr  <= addr;
                    mem_we    <= we;
                    mem_wdata <= wdata;
                    state     <= BUSY;
                end
                BUSY: if (mem_ack) begin
                    state <= DONE;
                    if (!mem_we) rdata <= mem_rdata;
                end else if (timeout) begin
                    state <= DONE;
                    if (!mem_we) rdata <= 8'hFF;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb_cpu_bus_ctrl: directed vectors for cpu_bus_ctrl; timeout checks follow CPU_BUS_TIMEOUT_EN.
module tb_cpu_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  rdata;
    logic        done;
    logic        stall;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    cpu_bus_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rdata(rdata),
        .done(done), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, output int cnt);
        cnt = 0;
        while (!done && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_stall", stall, 0);

        // zero-wait read
        req = 1'b1; we = 1'b0; addr = 16'h1234; wdata = 8'h5A;
        #1;
        chk("zw_stall_idle", stall, 1);
        tick();
        chk("zw_mem_req", mem_req, 1);
        chk("zw_mem_addr", mem_addr, 16'h1234);
        chk("zw_mem_we", mem_we, 0);
        chk("zw_stall_busy", stall, 1);
        mem_ack = 1'b1; mem_rdata = 8'hAA;
        tick();
        chk("zw_done", done, 1);
        chk("zw_rdata", rdata, 8'hAA);
        chk("zw_stall_done", stall, 0);
        chk("zw_mem_req_done", mem_req, 0);
        req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("zw_done_pulse", done, 0);
        chk("zw_mem_addr_hold", mem_addr, 16'h1234);

        // wait-state write
        req = 1'b1; we = 1'b1; addr = 16'h01FD; wdata = 8'hCC;
        tick();
        addr = 16'hFFFF; wdata = 8'h11; we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ws_mem_req", mem_req, 1);
            chk("ws_mem_we", mem_we, 1);
            chk("ws_mem_wdata", mem_wdata, 8'hCC);
            chk("ws_mem_addr", mem_addr, 16'h01FD);
            chk("ws_no_done", done, 0);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 8'h99;
        tick();
        chk("ws_done", done, 1);
        chk("ws_rdata_kept", rdata, 8'hAA);
        chk("ws_mem_wdata_done", mem_wdata, 8'hCC);
        req = 1'b0; mem_ack = 1'b0;
        tick();

        // back-to-back reads with req held
        req = 1'b1; we = 1'b0; addr = 16'h2000;
        tick();
        mem_ack = 1'b1; mem_rdata = 8'h55;
        tick();
        chk("bb_done1", done, 1);
        chk("bb_rdata1", rdata, 8'h55);
        addr = 16'h2001; mem_rdata = 8'hF0;
        tick();
        chk("bb_idle_done", done, 0);
        chk("bb_idle_mem_req", mem_req, 0);
        chk("bb_idle_addr", mem_addr, 16'h2000);
        chk("bb_idle_stall", stall, 1);
        chk("bb_ack_in_done_ignored", rdata, 8'h55);
        mem_ack = 1'b0;
        tick();
        chk("bb_busy2", mem_req, 1);
        chk("bb_addr2", mem_addr, 16'h2001);
        mem_ack = 1'b1;
        tick();
        chk("bb_done2", done, 1);
        chk("bb_rdata2", rdata, 8'hF0);
        req = 1'b0; mem_ack = 1'b0;
        tick();

        // stray ack in IDLE
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        chk("stray_mem_req", mem_req, 0);
        chk("stray_done", done, 0);
        chk("stray_rdata", rdata, 8'hF0);
        mem_ack = 1'b0;
        tick();
        chk("stray_mem_req2", mem_req, 0);

        // reset during BUSY
        req = 1'b1; we = 1'b1; addr = 16'h3333; wdata = 8'h44;
        tick();
        chk("rb_busy", mem_req, 1);
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rb_mem_req", mem_req, 0);
        chk("rb_mem_addr", mem_addr, 16'h0000);
        chk("rb_mem_wdata", mem_wdata, 8'h00);
        chk("rb_mem_we", mem_we, 0);
        chk("rb_rdata", rdata, 8'h00);
        chk("rb_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rb_after_done", done, 0);
        chk("rb_after_mem_req", mem_req, 0);

        // read with no ack
        req = 1'b1; we = 1'b0; addr = 16'h4444;
        tick();
`ifdef CPU_BUS_TIMEOUT_EN
        wait_done(40, n);
        chk("to_latency", n, 16);
        chk("to_rdata", rdata, 8'hFF);
        chk("to_err", err, 1);
        req = 1'b0;
        tick();
        tick();
        chk("to_err_sticky", err, 1);
        req = 1'b1; we = 1'b1; addr = 16'h5555;
        tick();
        chk("to_err_clear", err, 0);
        mem_ack = 1'b1;
        tick();
        chk("to_next_done", done, 1);
        chk("to_next_err", err, 0);
        req = 1'b0; mem_ack = 1'b0;
        tick();
`else
        wait_done(20, n);
        chk("to_hang_done", done, 0);
        chk("to_hang_mem_req", mem_req, 1);
        chk("to_hang_err", err, 0);
        req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("to_hang_reset", mem_req, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
